alu_cmd_sequencer: RTL and testbench

//   Initiator side of the 4-bit ALU interface. Accepts one command at a time
//   (opcode, a, b) on a valid/ready port and drives registered opcode/operands
//   to an external combinational ALU. Samples the ALU result after a fixed

---
 rtl/alu_cmd_sequencer.sv | 95 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts ALU commands, drives registered operands to an external ALU, returns the settled result.
// Optional accumulator-as-operand-a feature enabled by defining ALU_SEQ_ACC_EN.
module alu_cmd_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNTW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_acc,
    output logic [1:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_op,
    output logic [CNTW-1:0]  txn_count
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;
    state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d, rop_q, rop_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d, a_src;
    logic [CNTW-1:0]  txn_q, txn_d;
    logic             accept, capture, release_rsp;
    assign accept      = state_q == IDLE && cmd_valid;
    assign capture     = state_q == DRIVE && cnt_q == '0;
    assign release_rsp = state_q == DONE && rsp_ready;
`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] acc_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else if (capture) acc_q <= alu_result;
    end
    assign a_src = cmd_acc ? acc_q : cmd_a;
`else
    logic unused_acc;
    assign unused_acc = cmd_acc;
    assign a_src = cmd_a;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = accept ? DRIVE : capture ? DONE : release_rsp ? IDLE : state_q;
    end
    always_comb begin
        cmd_ready = state_q == IDLE;
        rsp_valid = state_q == DONE;
    end
    // Operands load only on accept, so they cannot move while the ALU settles.
    always_comb begin
        op_d   = accept ? cmd_op : op_q;
        a_d    = accept ? a_src : a_q;
        b_d    = accept ? cmd_b : b_q;
        cnt_d  = accept ? CW'(SETTLE - 1) : (state_q == DRIVE && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        data_d = capture ? alu_result : data_q;
        rop_d  = capture ? op_q : rop_q;
        txn_d  = release_rsp ? txn_q + CNTW'(1) : txn_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            rop_q  <= '0;
            txn_q  <= '0;
        end else begin
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            rop_q  <= rop_d;
            txn_q  <= txn_d;
        end
    end
    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_data   = data_q;
    assign rsp_op     = rop_q;
    assign txn_count  = txn_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: randomized self-checking bench for alu_cmd_sequencer against a transaction-level model.
// Honours ALU_SEQ_ACC_EN the same way the design does.
module tb_alu_cmd_sequencer;
    localparam int SETTLE = 3;
    logic       clk = 0, rst = 0;
    logic       cmd_valid = 0, cmd_ready, cmd_acc = 0, rsp_valid, rsp_ready = 0;
    logic [1:0] cmd_op = 0, alu_opcode, rsp_op;
    logic [3:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_result, rsp_data;
    logic [3:0] perturb = 0;
    logic [7:0] txn_count;
    logic [7:0] cnt_m = 0;
    logic [3:0] acc_m = 0;
    int checks = 0, errors = 0;

    alu_cmd_sequencer #(.WIDTH(4), .SETTLE(SETTLE), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc), .alu_opcode(alu_opcode), .alu_a(alu_a),
        .alu_b(alu_b), .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int r;
        r = op == 2'b00 ? int'(a & b) : op == 2'b01 ? int'(a | b) : op == 2'b10 ? int'(a) + int'(b) : int'(a) - int'(b);
        return 4'(r % 16 + 16);
    endfunction

    // External ALU; perturb lets a test move the result while operands are held.
    assign alu_result = alu_f(alu_opcode, alu_a, alu_b) ^ perturb;

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic accf, input int hold, input bit pert, output logic [3:0] got);
        logic [3:0] ea, expv, last_p;
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_wait: cmd_ready=%b want 1", cmd_ready); end
        cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = accf;
`ifdef ALU_SEQ_ACC_EN
        ea = accf ? acc_m : a;
`else
        ea = a;
`endif
        @(negedge clk);
        cmd_valid = 0; cmd_op = 2'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_acc = 1'($urandom);
        cyc = 0; last_p = 0;
        while (rsp_valid !== 1'b1 && cyc < SETTLE + 5) begin
            checks++;
            if ({cmd_ready, alu_opcode, alu_a, alu_b} !== {1'b0, op, ea, b}) begin
                errors++;
                $display("FAIL drive_hold: rdy/op/a/b=%b/%b/%h/%h want 0/%b/%h/%h", cmd_ready, alu_opcode, alu_a, alu_b, op, ea, b);
            end
            if (pert) perturb = 4'($urandom);
            last_p = perturb;
            cmd_valid = 1'($urandom);
            rsp_ready = 1'($urandom);
            cyc++;
            @(negedge clk);
        end
        perturb = 0;
        cmd_valid = 0;
        rsp_ready = 0;
        expv = alu_f(op, ea, b) ^ last_p;
        checks++;
        if (cyc != SETTLE || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL latency: drive cycles=%0d rsp_valid=%b want %0d/1", cyc, rsp_valid, SETTLE);
        end
        checks++;
        if ({rsp_data, rsp_op} !== {expv, op}) begin
            errors++; $display("FAIL rsp: data=%h op=%b want %h/%b", rsp_data, rsp_op, expv, op);
        end
        got = rsp_data;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1; cmd_op = 2'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
            @(negedge clk);
            checks++;
            if ({rsp_valid, cmd_ready, rsp_data, rsp_op, txn_count, alu_a, alu_b} !== {1'b1, 1'b0, expv, op, cnt_m, ea, b}) begin
                errors++;
                $display("FAIL stall: v/rdy/data/op/cnt/a/b=%b/%b/%h/%b/%0d/%h/%h want 1/0/%h/%b/%0d/%h/%h",
                         rsp_valid, cmd_ready, rsp_data, rsp_op, txn_count, alu_a, alu_b, expv, op, cnt_m, ea, b);
            end
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        cnt_m = cnt_m + 8'd1;
        acc_m = expv;
        checks++;
        if ({txn_count, rsp_valid, cmd_ready, alu_opcode, alu_a, alu_b} !== {cnt_m, 1'b0, 1'b1, op, ea, b}) begin
            errors++;
            $display("FAIL release: cnt/v/rdy/op/a/b=%0d/%b/%b/%b/%h/%h want %0d/0/1/%b/%h/%h",
                     txn_count, rsp_valid, cmd_ready, alu_opcode, alu_a, alu_b, cnt_m, op, ea, b);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        cnt_m = 0; acc_m = 0;
        checks++;
        if ({alu_opcode, alu_a, alu_b, rsp_data, rsp_op, txn_count, rsp_valid, cmd_ready} !== {18'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: op/a/b/data/rop/cnt/v/rdy=%b/%h/%h/%h/%b/%0d/%b/%b want all 0, rdy 1",
                     alu_opcode, alu_a, alu_b, rsp_data, rsp_op, txn_count, rsp_valid, cmd_ready);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_ops();
        logic [3:0] got;
        logic [3:0] want [4] = '{4'b1000, 4'b1111, 4'b0111, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            run_cmd(2'(i), 4'b1101, 4'b1010, 1'b0, 0, 1'b0, got);
            checks++;
            if (got !== want[i]) begin errors++; $display("FAIL op%0d: got %b want %b", i, got, want[i]); end
        end
        checks++;
        if (txn_count !== 8'd4) begin errors++; $display("FAIL count4: got %0d want 4", txn_count); end
    endtask

    task automatic test_back_pressure();
        logic [3:0] got;
        run_cmd(2'b10, 4'h9, 4'h3, 1'b0, 5, 1'b0, got);
    endtask

    task automatic test_settle_glitch();
        logic [3:0] got;
        for (int i = 0; i < 3; i++) run_cmd(2'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1, 1'b1, got);
    endtask

    task automatic test_reset_midflight(input int stage);
        cmd_valid = 1; cmd_op = 2'b11; cmd_a = 4'hD; cmd_b = 4'hA; cmd_acc = 0;
        @(negedge clk);
        cmd_valid = 0;
        for (int i = 0; i < (stage == 0 ? 1 : SETTLE); i++) @(negedge clk);
        #2 rst = 1;
        #1;
        cnt_m = 0; acc_m = 0;
        checks++;
        if ({alu_opcode, alu_a, alu_b, rsp_data, rsp_op, txn_count, rsp_valid, cmd_ready} !== {18'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_stage%0d: op/a/b/data/rop/cnt/v/rdy=%b/%h/%h/%h/%b/%0d/%b/%b want all 0, rdy 1",
                     stage, alu_opcode, alu_a, alu_b, rsp_data, rsp_op, txn_count, rsp_valid, cmd_ready);
        end
        @(negedge clk);
        rst = 0;
        rsp_ready = 1;
        for (int i = 0; i < SETTLE + 3; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, txn_count} !== {1'b0, 8'd0}) begin
                errors++; $display("FAIL no_rsp_stage%0d: v=%b cnt=%0d want 0/0", stage, rsp_valid, txn_count);
            end
        end
        rsp_ready = 0;
    endtask

    task automatic test_acc();
        logic [3:0] got, want;
        run_cmd(2'b10, 4'b0011, 4'b0100, 1'b0, 0, 1'b0, got);
        run_cmd(2'b10, 4'b0101, 4'b0001, 1'b1, 0, 1'b0, got);
`ifdef ALU_SEQ_ACC_EN
        want = 4'b1000;
`else
        want = 4'b0110;
`endif
        checks++;
        if (got !== want) begin errors++; $display("FAIL acc: got %b want %b", got, want); end
    endtask

    task automatic test_random();
        logic [3:0] got;
        for (int i = 0; i < 262; i++)
            run_cmd(2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), got);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ops();
        test_back_pressure();
        test_settle_glitch();
        test_reset_midflight(0);
        test_ops();
        test_reset_midflight(1);
        test_acc();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
